// File: rtl/microarquitetura_keys_pio_pkg.sv
// Shared register map, edge encodings and edge-detect helper for the PIO blocks.
package microarquitetura_keys_pio_pkg;

   // Register word offsets on the Avalon-MM slave
   localparam logic [1:0] PIO_DATA    = 2'd0;
   localparam logic [1:0] PIO_RSVD    = 2'd1;
   localparam logic [1:0] PIO_IRQMASK = 2'd2;
   localparam logic [1:0] PIO_EDGECAP = 2'd3;

   // Edge selection for edgecapture
   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   // True when the transition old_v -> new_v matches the selected edge type
   function automatic logic edge_hit(input logic old_v, input logic new_v, input int edge_type);
      logic hit;
      hit = 1'b0;
      case (edge_type)
         EDGE_RISING:  hit = ~old_v & new_v;
         EDGE_FALLING: hit = old_v & ~new_v;
         default:      hit = old_v ^ new_v;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/microarquitetura_debounce_bit.sv
// One input bit: two-flop synchroniser, stability counter and debounced flop.
// deb_next_o exposes the value deb will take at the next clock so the parent
// can detect edges on the same clock that deb updates.
module microarquitetura_debounce_bit #(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic RESET_VAL       = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_bit,
   output logic deb_o,
   output logic deb_next_o
);

   // A zero-cycle debounce still needs a legal one-bit counter vector
   localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (DEBOUNCE_CYCLES > 0) ? CNT_W'(DEBOUNCE_CYCLES - 1) : '0;

   logic             sync0_q, sync0_d;
   logic             sync1_q, sync1_d;
   logic             deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state: accept a change only after it has differed for DEBOUNCE_CYCLES clocks
   always_comb begin
      sync0_d = in_bit;
      sync1_d = sync0_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      if (DEBOUNCE_CYCLES == 0) begin
         deb_d = sync1_q;
      end else if (sync1_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = sync1_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State registers; reset drops any change that was still being counted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync0_q <= RESET_VAL;
         sync1_q <= RESET_VAL;
         deb_q   <= RESET_VAL;
         cnt_q   <= '0;
      end else begin
         sync0_q <= sync0_d;
         sync1_q <= sync1_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

   assign deb_o      = deb_q;
   assign deb_next_o = deb_d;

endmodule

// File: rtl/microarquitetura_keys_pio.sv
// Avalon-MM input PIO for keys/switches: debounced data, irq mask and
// write-one-to-clear edge capture with a level interrupt.
module microarquitetura_keys_pio
   import microarquitetura_keys_pio_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter int               EDGE_TYPE       = EDGE_FALLING,
   parameter logic [WIDTH-1:0] IN_RESET_VAL    = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read_n,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] deb_w, deb_next_w, edge_w, clr_w;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             rd_w, wr_w;
   logic [31:0]      unused_wdata;

   // Only the low WIDTH bits of writedata carry register content
   assign unused_wdata = writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      microarquitetura_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (IN_RESET_VAL[i])
      ) u_deb (
         .clk        (clk),
         .reset_n    (reset_n),
         .in_bit     (in_port[i]),
         .deb_o      (deb_w[i]),
         .deb_next_o (deb_next_w[i])
      );
   end

   assign rd_w = chipselect & ~read_n;
   assign wr_w = chipselect & ~write_n;

   // Register next-state: edge set beats a simultaneous software clear; reads see pre-write values
   always_comb begin
      irqmask_d  = irqmask_q;
      readdata_d = readdata_q;
      clr_w      = '0;
      edge_w     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         edge_w[i] = edge_hit(deb_w[i], deb_next_w[i], EDGE_TYPE);
      end
      if (wr_w && address == PIO_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
      if (wr_w && address == PIO_EDGECAP) clr_w = writedata[WIDTH-1:0];
      edgecap_d = (edgecap_q & ~clr_w) | edge_w;
      if (rd_w) begin
         readdata_d = '0;
         case (address)
            PIO_DATA:    readdata_d[WIDTH-1:0] = deb_w;
            PIO_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            PIO_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:     readdata_d = '0;
         endcase
      end
   end

   // Bus-visible registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask_q  <= '0;
         edgecap_q  <= '0;
         readdata_q <= '0;
      end else begin
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_microarquitetura_keys_pio.sv
module tb_microarquitetura_keys_pio;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int test_cnt = 0;
   int fail_cnt = 0;

   microarquitetura_keys_pio #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (4),
      .EDGE_TYPE       (1),
      .IN_RESET_VAL    (4'hF)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .read_n     (read_n),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   // Clock: inputs change and outputs are sampled on the falling edge
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      test_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      chipselect = 1'b0;
      read_n     = 1'b1;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      chipselect = 1'b1;
      read_n     = 1'b0;
      address    = a;
      tick(1);
      d = readdata;
      bus_idle();
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick(1);
      bus_idle();
   endtask

   initial begin
      logic [31:0] rd;
      reset_n = 1'b0;
      address = 2'd0;
      in_port = 4'hF;
      bus_idle();

      // 1. Reset values and first reads
      tick(3);
      check("rst_readdata", readdata, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      reset_n = 1'b1;
      tick(2);
      bus_read(2'd0, rd);  check("t1_data", rd, 32'h0000000F);
      bus_read(2'd3, rd);  check("t1_edgecap", rd, 32'h0);
      bus_read(2'd1, rd);  check("t1_reserved", rd, 32'h0);
      check("t1_irq", {31'b0, irq}, 32'h0);

      // 2. Bit0 falls; continuous data read pins deb latency to 6 clocks
      in_port    = 4'hE;
      chipselect = 1'b1;
      read_n     = 1'b0;
      address    = 2'd0;
      tick(6);
      check("t2_data_before", readdata, 32'h0000000F);
      tick(1);
      check("t2_data_after", readdata, 32'h0000000E);
      bus_idle();
      bus_read(2'd3, rd);  check("t2_edgecap", rd, 32'h1);
      check("t2_irq_masked", {31'b0, irq}, 32'h0);

      // 3. Unmask raises irq; W1C clears capture and irq
      bus_write(2'd2, 32'h1);
      check("t3_irq_set", {31'b0, irq}, 32'h1);
      bus_write(2'd3, 32'h1);
      check("t3_irq_clr", {31'b0, irq}, 32'h0);
      bus_read(2'd3, rd);  check("t3_edgecap", rd, 32'h0);
      bus_write(2'd0, 32'h0);
      bus_read(2'd0, rd);  check("t3_data_ro", rd, 32'h0000000E);

      // 4. Three-clock glitch on bit1 is rejected
      in_port = 4'hC;
      tick(3);
      in_port = 4'hE;
      tick(8);
      bus_read(2'd0, rd);  check("t4_data", rd, 32'h0000000E);
      bus_read(2'd3, rd);  check("t4_edgecap", rd, 32'h0);

      // 5. Clear of bit2 on the very clock its fall lands: set wins
      in_port = 4'hA;
      tick(5);
      bus_write(2'd3, 32'h4);
      bus_read(2'd3, rd);  check("t5_edgecap", rd, 32'h4);
      check("t5_irq", {31'b0, irq}, 32'h0);

      // Read and write to irqmask together returns the old mask
      chipselect = 1'b1;
      read_n     = 1'b0;
      write_n    = 1'b0;
      address    = 2'd2;
      writedata  = 32'h5;
      tick(1);
      check("rw_old_mask", readdata, 32'h1);
      bus_idle();
      bus_read(2'd2, rd);  check("rw_new_mask", rd, 32'h5);
      check("rw_irq", {31'b0, irq}, 32'h1);

      // 6. Reset mid-count on bit3
      in_port = 4'h2;
      tick(4);
      reset_n = 1'b0;
      tick(2);
      check("t6_rst_readdata", readdata, 32'h0);
      check("t6_rst_irq", {31'b0, irq}, 32'h0);
      reset_n    = 1'b1;
      chipselect = 1'b1;
      read_n     = 1'b0;
      address    = 2'd3;
      tick(6);
      check("t6_no_cap_yet", readdata, 32'h0);
      tick(1);
      check("t6_cap", readdata, 32'h0000000D);
      bus_idle();
      bus_read(2'd0, rd);  check("t6_data", rd, 32'h00000002);
      bus_read(2'd2, rd);  check("t6_mask", rd, 32'h0);
      check("t6_irq", {31'b0, irq}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
